decode_ctrl_stage: RTL and testbench

//  Registered, parametrised successor of the single-cycle main decoder. Decodes a 32-bit MIPS word

---
 rtl/ctrl_pkg.sv | 138 +++++++++++++
 rtl/ctrl_decode.sv | 172 +++++++++++++++++
 rtl/decode_ctrl_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the registered MIPS decode stage:
//   ctrl_t   - 31-bit packed control word (first field is the MSB)
//   OP_*     - primary opcode values (instr[31:26])
//   FN_*     - R-type funct values (instr[5:0])
//   RT_*     - REGIMM rt selectors (instr[20:16])
//   ALU_*    - team ALU operation encodings carried in ctrl_t.alu_op
// Field meanings that are not self-evident:
//   shamt_sel : 2'b01 shift amount from shamt field, 2'b10 from rs register
//   lh_to_reg : 2'b01 write LO to rd, 2'b10 write HI to rd
//   extr_word : 2'b00 word, 2'b01 byte, 2'b10 halfword load extraction
//   to_lh     : result is written to the HI/LO pair
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int CTRL_W = 31;

  typedef struct packed {
    logic       jmp;
    logic       jr;
    logic       jal;
    logic       beq;
    logic       bne;
    logic       bltz;
    logic       blez;
    logic       bgez;
    logic       bgtz;
    logic       mem_to_reg;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       syscall;
    logic       signed_ext;
    logic [1:0] extr_word;
    logic       to_lh;
    logic       extr_signed;
    logic       sh;
    logic       sb;
    logic [1:0] shamt_sel;
    logic [1:0] lh_to_reg;
    logic       illegal;
  } ctrl_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // Team ALU table
  localparam logic [3:0] ALU_SLL   = 4'b0000;
  localparam logic [3:0] ALU_SRL   = 4'b0001;
  localparam logic [3:0] ALU_SRA   = 4'b0010;
  localparam logic [3:0] ALU_MULTU = 4'b0011;
  localparam logic [3:0] ALU_DIVU  = 4'b0100;
  localparam logic [3:0] ALU_ADD   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1011;
  localparam logic [3:0] ALU_SLTU  = 4'b1100;
  localparam logic [3:0] ALU_LUI   = 4'b1101;

  // Common R-type ALU result written to rd
  function automatic ctrl_t ctrl_rtype(input logic [3:0] alu);
    ctrl_t c;
    c           = '0;
    c.reg_write = 1'b1;
    c.reg_dst   = 1'b1;
    c.alu_op    = alu;
    return c;
  endfunction

  // Immediate-operand ALU result written to rt
  function automatic ctrl_t ctrl_itype(input logic [3:0] alu, input logic sext);
    ctrl_t c;
    c            = '0;
    c.reg_write  = 1'b1;
    c.alu_src_b  = 1'b1;
    c.signed_ext = sext;
    c.alu_op     = alu;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational MIPS main decoder: instruction word -> ctrl_t.
// Ports:
//   instr_i  in  32  instruction word
//   ctrl_o   out 31  packed ctrl_t
//   is_md_o  out  1  word is MULTU or DIVU (starts HI/LO occupancy)
//   is_mf_o  out  1  word is MFHI or MFLO (reads HI/LO)
// Configuration macro: DECODE_ILLEGAL_TRAP_EN
//   defined   - unrecognised words give ctrl with only illegal=1
//   undefined - unrecognised words give all-zero ctrl (NOP)
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              is_md_o,
  output logic              is_mf_o
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  ctrl_t      dec_s;
  logic       unk_s;
  logic       md_s;
  logic       mf_s;
  logic       unused_bits_s;

  assign op_s    = instr_i[31:26];
  assign rt_s    = instr_i[20:16];
  assign funct_s = instr_i[5:0];

  // Register numbers, shamt and immediates are consumed downstream, not here
  assign unused_bits_s = ^{instr_i[25:21], instr_i[15:6]};

  // Raw decode, flagging any word not in the supported set
  always_comb begin
    dec_s = '0;
    unk_s = 1'b0;
    md_s  = 1'b0;
    mf_s  = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_SLL:  begin dec_s = ctrl_rtype(ALU_SLL); dec_s.shamt_sel = 2'b01; end
          FN_SRL:  begin dec_s = ctrl_rtype(ALU_SRL); dec_s.shamt_sel = 2'b01; end
          FN_SRA:  begin dec_s = ctrl_rtype(ALU_SRA); dec_s.shamt_sel = 2'b01; end
          FN_SLLV: begin dec_s = ctrl_rtype(ALU_SLL); dec_s.shamt_sel = 2'b10; end
          FN_SRLV: begin dec_s = ctrl_rtype(ALU_SRL); dec_s.shamt_sel = 2'b10; end
          FN_SRAV: begin dec_s = ctrl_rtype(ALU_SRA); dec_s.shamt_sel = 2'b10; end
          FN_JR:      dec_s.jr = 1'b1;
          FN_SYSCALL: dec_s.syscall = 1'b1;
          FN_MFHI: begin
            dec_s           = ctrl_rtype(4'b0000);
            dec_s.lh_to_reg = 2'b10;
            mf_s            = 1'b1;
          end
          FN_MFLO: begin
            dec_s           = ctrl_rtype(4'b0000);
            dec_s.lh_to_reg = 2'b01;
            mf_s            = 1'b1;
          end
          FN_MULTU: begin
            dec_s.to_lh  = 1'b1;
            dec_s.alu_op = ALU_MULTU;
            md_s         = 1'b1;
          end
          FN_DIVU: begin
            dec_s.to_lh  = 1'b1;
            dec_s.alu_op = ALU_DIVU;
            md_s         = 1'b1;
          end
          FN_ADD, FN_ADDU: dec_s = ctrl_rtype(ALU_ADD);
          FN_SUB, FN_SUBU: dec_s = ctrl_rtype(ALU_SUB);
          FN_AND:  dec_s = ctrl_rtype(ALU_AND);
          FN_OR:   dec_s = ctrl_rtype(ALU_OR);
          FN_XOR:  dec_s = ctrl_rtype(ALU_XOR);
          FN_NOR:  dec_s = ctrl_rtype(ALU_NOR);
          FN_SLT:  dec_s = ctrl_rtype(ALU_SLT);
          FN_SLTU: dec_s = ctrl_rtype(ALU_SLTU);
          default: unk_s = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ: begin dec_s.bltz = 1'b1; dec_s.signed_ext = 1'b1; end
          RT_BGEZ: begin dec_s.bgez = 1'b1; dec_s.signed_ext = 1'b1; end
          default: unk_s = 1'b1;
        endcase
      end
      OP_BLEZ: begin
        if (rt_s == 5'd0) begin
          dec_s.blez       = 1'b1;
          dec_s.signed_ext = 1'b1;
        end else begin
          unk_s = 1'b1;
        end
      end
      OP_BGTZ: begin
        if (rt_s == 5'd0) begin
          dec_s.bgtz       = 1'b1;
          dec_s.signed_ext = 1'b1;
        end else begin
          unk_s = 1'b1;
        end
      end
      OP_J: dec_s.jmp = 1'b1;
      OP_JAL: begin
        dec_s.jal       = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OP_BEQ: begin
        dec_s.beq        = 1'b1;
        dec_s.alu_op     = ALU_SUB;
        dec_s.signed_ext = 1'b1;
      end
      OP_BNE: begin
        dec_s.bne        = 1'b1;
        dec_s.alu_op     = ALU_SUB;
        dec_s.signed_ext = 1'b1;
      end
      OP_ADDI, OP_ADDIU: dec_s = ctrl_itype(ALU_ADD, 1'b1);
      OP_SLTI:  dec_s = ctrl_itype(ALU_SLT, 1'b1);
      OP_SLTIU: dec_s = ctrl_itype(ALU_SLTU, 1'b1);
      OP_ANDI:  dec_s = ctrl_itype(ALU_AND, 1'b0);
      OP_ORI:   dec_s = ctrl_itype(ALU_OR, 1'b0);
      OP_XORI:  dec_s = ctrl_itype(ALU_XOR, 1'b0);
      OP_LUI:   dec_s = ctrl_itype(ALU_LUI, 1'b0);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_s            = ctrl_itype(ALU_ADD, 1'b1);
        dec_s.mem_to_reg = 1'b1;
        case (op_s)
          OP_LB:   begin dec_s.extr_word = 2'b01; dec_s.extr_signed = 1'b1; end
          OP_LH:   begin dec_s.extr_word = 2'b10; dec_s.extr_signed = 1'b1; end
          OP_LBU:  dec_s.extr_word = 2'b01;
          OP_LHU:  dec_s.extr_word = 2'b10;
          default: dec_s.extr_word = 2'b00;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_s            = ctrl_itype(ALU_ADD, 1'b1);
        dec_s.reg_write  = 1'b0;
        dec_s.mem_write  = 1'b1;
        case (op_s)
          OP_SB:   dec_s.sb = 1'b1;
          OP_SH:   dec_s.sh = 1'b1;
          default: dec_s.sb = 1'b0;
        endcase
      end
      default: unk_s = 1'b1;
    endcase
  end

  // Final control word: unrecognised words collapse to NOP or to a trap marker
  always_comb begin
    if (unk_s) begin
      ctrl_o  = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ctrl_o[0] = 1'b1;  // illegal is the LSB of ctrl_t
`endif
      is_md_o = 1'b0;
      is_mf_o = 1'b0;
    end else begin
      ctrl_o  = dec_s;
      is_md_o = md_s;
      is_mf_o = mf_s;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage
// Registered decode stage between fetch and execute. Decodes the incoming
// word, holds up to two decoded entries (main + skid) behind valid/ready
// handshakes and stalls HI/LO readers/writers while the multiply/divide
// unit is still busy.
// Parameters:
//   MUL_LAT  busy cycles after an accepted MULTU (1..255)
//   DIV_LAT  busy cycles after an accepted DIVU  (1..255)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop both entries, block accept this cycle
//   in_valid/in_ready     upstream handshake, in_instr word
//   out_valid/out_ready   downstream handshake, out_instr/out_ctrl
//   md_busy               HI/LO occupancy counter non-zero
//   out_exc               reserved-instruction exception
// Configuration macro: DECODE_ILLEGAL_TRAP_EN (out_exc tied 0 when undefined)
// ---------------------------------------------------------------------------
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [30:0] out_ctrl,
  output logic        md_busy,
  output logic        out_exc
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_t      dec_ctrl_s;
  logic       dec_is_md_s;
  logic       dec_is_mf_s;
  logic       hazard_s;
  logic       accept_s;
  logic       pop_s;

  logic       main_valid_q, main_valid_d;
  ctrl_t      main_ctrl_q,  main_ctrl_d;
  logic [31:0] main_instr_q, main_instr_d;
  logic       skid_valid_q, skid_valid_d;
  ctrl_t      skid_ctrl_q,  skid_ctrl_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_decode u_decode (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl_s),
    .is_md_o (dec_is_md_s),
    .is_mf_o (dec_is_mf_s)
  );

  // A HI/LO user must wait until the previous MD op has drained
  assign hazard_s = (dec_is_md_s | dec_is_mf_s) & (cnt_q != '0);
  assign in_ready = ~skid_valid_q & ~hazard_s & ~flush;
  assign accept_s = in_valid & in_ready;
  assign pop_s    = main_valid_q & out_ready;

  // Two-entry buffer next state; skid only fills when main is stuck
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty
      if (accept_s) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = dec_ctrl_s;
        main_instr_d = in_instr;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (pop_s) begin
      if (skid_valid_q) begin
        main_ctrl_d  = skid_ctrl_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        // Direct reload keeps full throughput without a bubble
        main_ctrl_d  = dec_ctrl_s;
        main_instr_d = in_instr;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = dec_ctrl_s;
        skid_instr_d = in_instr;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // HI/LO occupancy: load on an accepted MD op, otherwise count down to zero.
  // flush leaves it alone since an accepted MD op still runs to completion.
  always_comb begin
    if (accept_s && dec_is_md_s) begin
      if (dec_ctrl_s.alu_op == ALU_MULTU) begin
        cnt_d = MUL_LOAD;
      end else begin
        cnt_d = DIV_LOAD;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_instr_q <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_instr_q <= 32'h0000_0000;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_instr_q <= skid_instr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_instr = main_instr_q;
  assign md_busy   = (cnt_q != '0);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_exc = main_valid_q & main_ctrl_q.illegal;
`else
  assign out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [30:0] out_ctrl;
  logic        md_busy;
  logic        out_exc;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    ctrl_t       exp;
  } sb_t;

  localparam int NV = 21;
  vec_t tbl[NV];
  sb_t  sbq[$];

  decode_ctrl_stage #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_ctrl  (out_ctrl),
    .md_busy   (md_busy),
    .out_exc   (out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout", nm);
  endtask

  function automatic ctrl_t e_r(input logic [3:0] a);
    ctrl_t c;
    c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = a;
    return c;
  endfunction

  function automatic ctrl_t e_i(input logic [3:0] a, input logic sx);
    ctrl_t c;
    c = '0; c.reg_write = 1'b1; c.alu_src_b = 1'b1; c.signed_ext = sx; c.alu_op = a;
    return c;
  endfunction

  function automatic ctrl_t e_ill();
    ctrl_t c;
    c = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    c.illegal = 1'b1;
`endif
    return c;
  endfunction

  task automatic build_table();
    ctrl_t c;
    tbl[0]  = '{32'h00221820, e_r(4'b0101)};  // ADD
    tbl[1]  = '{32'h00221822, e_r(4'b0110)};  // SUB
    tbl[2]  = '{32'h00221824, e_r(4'b0111)};  // AND
    tbl[3]  = '{32'h00221825, e_r(4'b1000)};  // OR
    tbl[4]  = '{32'h0022182A, e_r(4'b1011)};  // SLT
    tbl[5]  = '{32'h20220005, e_i(4'b0101, 1'b1)};  // ADDI
    c = e_i(4'b0101, 1'b1); c.mem_to_reg = 1'b1;
    tbl[6]  = '{32'h8C220004, c};  // LW
    c = e_i(4'b0101, 1'b1); c.reg_write = 1'b0; c.mem_write = 1'b1;
    tbl[7]  = '{32'hAC220004, c};  // SW
    c = '0; c.beq = 1'b1; c.alu_op = 4'b0110; c.signed_ext = 1'b1;
    tbl[8]  = '{32'h10220003, c};  // BEQ
    c = '0; c.jmp = 1'b1;
    tbl[9]  = '{32'h08000010, c};  // J
    c = '0; c.jr = 1'b1;
    tbl[10] = '{32'h03E00008, c};  // JR
    c = '0; c.to_lh = 1'b1; c.alu_op = 4'b0011;
    tbl[11] = '{32'h00220019, c};  // MULTU
    c = e_r(4'b0000); c.lh_to_reg = 2'b10;
    tbl[12] = '{32'h00001810, c};  // MFHI (stalls behind MULTU)
    c = '0; c.bgez = 1'b1; c.signed_ext = 1'b1;
    tbl[13] = '{32'h04210002, c};  // BGEZ
    tbl[14] = '{32'h04220002, e_ill()};  // REGIMM rt=2
    c = e_r(4'b0000); c.shamt_sel = 2'b01;
    tbl[15] = '{32'h00021900, c};  // SLL
    c = e_i(4'b0101, 1'b1); c.mem_to_reg = 1'b1; c.extr_word = 2'b01; c.extr_signed = 1'b1;
    tbl[16] = '{32'h80220001, c};  // LB
    c = e_i(4'b0101, 1'b1); c.reg_write = 1'b0; c.mem_write = 1'b1; c.sh = 1'b1;
    tbl[17] = '{32'hA4220002, c};  // SH
    c = '0; c.syscall = 1'b1;
    tbl[18] = '{32'h0000000C, c};  // SYSCALL
    tbl[19] = '{32'h34220005, e_i(4'b1000, 1'b0)};  // ORI
    c = '0; c.jal = 1'b1; c.reg_write = 1'b1;
    tbl[20] = '{32'h0C000010, c};  // JAL
  endtask

  initial begin
    ctrl_t ce;
    int    stalls;
    int    cyc_a;
    int    popped;
    bit    got;

    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
    build_table();

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_out_ctrl", {1'b0, out_ctrl}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_exc", {31'd0, out_exc}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ADD, 1-cycle latency
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221820;
    @(negedge clk);
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    ce = out_ctrl;
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_reg_write", {31'd0, ce.reg_write}, 32'd1);
    chk("add_reg_dst", {31'd0, ce.reg_dst}, 32'd1);
    chk("add_alu_op", {28'd0, ce.alu_op}, 32'd5);
    chk("add_instr", out_instr, 32'h00221820);

    // Backpressure: two words fill main+skid, third waits
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820;
    @(negedge clk); chk("bp_acc1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_instr = 32'h00221822;
    @(negedge clk); chk("bp_acc2", {31'd0, in_ready}, 32'd1);
    chk("bp_main1", out_instr, 32'h00221820);
    @(posedge clk); #1 in_instr = 32'h00221825;
    @(negedge clk); chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("bp_hold_w1", out_instr, 32'h00221820);
    chk("bp_ready_skidfull", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_w2", out_instr, 32'h00221822);
    chk("bp_w3_acc", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("bp_w3", out_instr, 32'h00221825);
    chk("bp_w3_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // MULTU then MFLO: exactly MUL_LAT stall cycles
    @(posedge clk); #1 in_valid = 1'b1; in_instr = 32'h00220019;
    @(negedge clk); chk("mul_acc", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_instr = 32'h00001812;
    stalls = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      chk("mul_busy_during", {31'd0, md_busy}, 32'd1);
      stalls++;
      @(posedge clk); #1;
    end
    if (!got) timeout("mul_stall");
    chk("mul_stalls", stalls, 32'd4);
    chk("mul_busy_after", {31'd0, md_busy}, 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    ce = out_ctrl;
    chk("mflo_instr", out_instr, 32'h00001812);
    chk("mflo_lh_to_reg", {30'd0, ce.lh_to_reg}, 32'd1);

    // Flush with both entries full; counter keeps running
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0022001B;
    @(negedge clk); chk("fl_divu_acc", {31'd0, in_ready}, 32'd1);
    cyc_a = cyc;
    @(posedge clk); #1 in_instr = 32'h00221820;
    @(negedge clk); chk("fl_add_acc", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_instr = 32'h00221822; flush = 1'b1;
    @(negedge clk); chk("fl_block", {31'd0, in_ready}, 32'd0);
    chk("fl_busy_pre", {31'd0, md_busy}, 32'd1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_busy_post", {31'd0, md_busy}, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("fl_skid_gone", {31'd0, out_valid}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!md_busy) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) timeout("div_drain");
    chk("div_busy_len", cyc - cyc_a, 32'd33);

    // Reserved opcode
    @(posedge clk); #1 in_valid = 1'b1; in_instr = 32'hFC000000;
    @(negedge clk); chk("ill_acc", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_ctrl", {1'b0, out_ctrl}, {1'b0, e_ill()});
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_exc", {31'd0, out_exc}, 32'd1);
`else
    chk("ill_exc", {31'd0, out_exc}, 32'd0);
`endif
    @(posedge clk); #1;

    // Table stream with random backpressure and scoreboard
    popped = 0;
    fork
      begin : driver
        for (int k = 0; k < NV; k++) begin
          bit ok;
          ok = 1'b0;
          in_valid = 1'b1;
          in_instr = tbl[k].instr;
          for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (in_ready) begin
              sbq.push_back('{tbl[k].instr, tbl[k].exp});
              ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
          end
          if (!ok) timeout("tbl_accept");
        end
        in_valid = 1'b0;
      end
      begin : monitor
        for (int t = 0; t < 3000 && popped < NV; t++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
              timeout("sb_underflow");
            end else begin
              sb_t e;
              e = sbq.pop_front();
              chk("tbl_instr", out_instr, e.instr);
              chk("tbl_ctrl", {1'b0, out_ctrl}, {1'b0, e.exp});
            end
            popped++;
          end
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        if (popped < NV) timeout("tbl_drain");
      end
    join
    out_ready = 1'b1;
    chk("tbl_count", popped, NV);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
